stopwatch_counter: RTL and testbench

- Stopwatch core that consumes the tick outputs of the clock divider and produces the MM:SS BCD digits plus per-digit blanking for the 7-segment display driver.
- Runs entirely on clk_in. The divider outputs clk_1hz, clk_2hz and clk_blink are sampled as ordinary synchronous level inputs and edge-detected; they are never used as clocks.
- Handles run/pause toggling and a minute/second adjust mode.

---
 rtl/stopwatch_counter.sv | 64 ++++++
 tb/tb_stopwatch_counter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD stopwatch with run/pause, adjust mode and per-digit blanking
module stopwatch_counter #(
    parameter int SEC_TENS_MAX = 5,
    parameter int MIN_TENS_MAX = 5
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       clk_blink,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] blank,
    output logic       paused
);
    // bit 1 = adjust mode, bit 0 = held; next adjust bit follows adj, held bit toggles on pause
    typedef enum logic [1:0] {RUN = 2'b00, HOLD = 2'b01, ADJ_RUN = 2'b10, ADJ_HOLD = 2'b11} state_t;
    state_t state, state_next;
    logic prev_1hz, prev_2hz, tick1, tick2, run_tick, sec_wrap, inc_sec, inc_min;
    logic [3:0] sec_ones_n, sec_tens_n, min_ones_n, min_tens_n, blank_n;
    always_comb begin
        tick1      = clk_1hz & ~prev_1hz;
        tick2      = clk_2hz & ~prev_2hz;
        state_next = state_t'({adj, state[0] ^ pause_pulse});
        run_tick   = (state == RUN) & tick1 & ~adj;
        sec_wrap   = (sec_tens == 4'(SEC_TENS_MAX)) & (sec_ones == 4'd9);
        inc_sec    = run_tick | (state[1] & tick2 & sel);
        inc_min    = (run_tick & sec_wrap) | (state[1] & tick2 & ~sel);
        sec_ones_n = inc_sec ? ((sec_ones == 4'd9) ? 4'd0 : sec_ones + 4'd1) : sec_ones;
        sec_tens_n = (inc_sec & (sec_ones == 4'd9))
                   ? ((sec_tens == 4'(SEC_TENS_MAX)) ? 4'd0 : sec_tens + 4'd1) : sec_tens;
        min_ones_n = inc_min ? ((min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1) : min_ones;
        min_tens_n = (inc_min & (min_ones == 4'd9))
                   ? ((min_tens == 4'(MIN_TENS_MAX)) ? 4'd0 : min_tens + 4'd1) : min_tens;
        blank_n    = (state_next[1] & clk_blink) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
        paused     = state[0];
    end
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state    <= RUN;
            prev_1hz <= 1'b0;
            prev_2hz <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            blank    <= 4'b0000;
        end else begin
            state    <= state_next;
            prev_1hz <= clk_1hz;
            prev_2hz <= clk_2hz;
            sec_ones <= sec_ones_n;
            sec_tens <= sec_tens_n;
            min_ones <= min_ones_n;
            min_tens <= min_tens_n;
            blank    <= blank_n;
        end
    end
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed plus random stimulus checked against a time-based reference model
module tb_stopwatch_counter;
    logic clk_in = 1'b0, rst = 1'b1, clk_1hz = 1'b0, clk_2hz = 1'b0, clk_blink = 1'b0;
    logic pause_pulse = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
    logic paused;
    int errors = 0, checks = 0;
    int m_min = 0, m_sec = 0;
    bit m_hold = 0, m_adj = 0, m_p1 = 0, m_p2 = 0;
    logic [3:0] m_blank = 4'b0000;

    stopwatch_counter dut (
        .clk_in(clk_in), .rst(rst), .clk_1hz(clk_1hz), .clk_2hz(clk_2hz), .clk_blink(clk_blink),
        .pause_pulse(pause_pulse), .adj(adj), .sel(sel), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .blank(blank), .paused(paused)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clk_in edge: advance the model from the inputs seen at the edge, then compare
    task automatic cyc();
        bit t1, t2;
        @(posedge clk_in);
        if (rst) begin
            m_min = 0; m_sec = 0; m_hold = 0; m_adj = 0; m_p1 = 0; m_p2 = 0; m_blank = 4'b0000;
        end else begin
            t1 = clk_1hz && !m_p1;
            t2 = clk_2hz && !m_p2;
            if (!m_adj && !m_hold && t1 && !adj) begin
                if (m_sec == 59) begin m_sec = 0; m_min = (m_min + 1) % 60; end
                else m_sec++;
            end
            if (m_adj && t2) begin
                if (sel) m_sec = (m_sec + 1) % 60;
                else m_min = (m_min + 1) % 60;
            end
            m_adj = adj;
            m_hold = m_hold ^ pause_pulse;
            m_blank = (adj && clk_blink) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
            m_p1 = clk_1hz;
            m_p2 = clk_2hz;
        end
        #1;
        chk("digits", {min_tens, min_ones, sec_tens, sec_ones}, bcd(m_min, m_sec));
        chk("blank", 16'(blank), 16'(m_blank));
        chk("paused", 16'(paused), 16'(m_hold));
    endtask

    task automatic pulse1(input int n);
        for (int i = 0; i < n; i++) begin clk_1hz = 1; cyc(); clk_1hz = 0; cyc(); end
    endtask

    task automatic pulse2(input int n);
        for (int i = 0; i < n; i++) begin clk_2hz = 1; cyc(); clk_2hz = 0; cyc(); end
    endtask

    task automatic pause();
        pause_pulse = 1; cyc(); pause_pulse = 0;
    endtask

    task automatic exp_time(input string tag, input int mm, input int ss);
        chk(tag, {min_tens, min_ones, sec_tens, sec_ones}, bcd(mm, ss));
    endtask

    initial begin
        cyc();
        rst = 0;
        exp_time("reset_digits", 0, 0);
        chk("reset_blank", 16'(blank), 16'h0);
        chk("reset_paused", 16'(paused), 16'h0);
        pulse1(3);
        exp_time("run_3", 0, 3);
        adj = 1; sel = 1; cyc();
        pulse2(55);
        sel = 0; pulse2(59);
        exp_time("preload", 59, 58);
        adj = 0; cyc();
        pulse1(1);
        exp_time("to_5959", 59, 59);
        pulse1(1);
        exp_time("wrap_0000", 0, 0);
        pulse1(5);
        pause();
        chk("hold_paused", 16'(paused), 16'h1);
        pulse1(4);
        exp_time("hold_frozen", 0, 5);
        pause();
        chk("resume_paused", 16'(paused), 16'h0);
        pulse1(1);
        exp_time("resume_6", 0, 6);
        pulse1(4);
        clk_1hz = 1; pause_pulse = 1; cyc(); clk_1hz = 0; pause_pulse = 0;
        exp_time("pause_tick_same", 0, 11);
        chk("pause_tick_paused", 16'(paused), 16'h1);
        pause(); cyc();
        pulse1(47);
        exp_time("at_58", 0, 58);
        adj = 1; sel = 1; cyc();
        pulse2(3);
        exp_time("adj_sec_nocarry", 0, 1);
        pulse1(2);
        exp_time("adj_1hz_ignored", 0, 1);
        clk_blink = 1; cyc();
        chk("blink_sec", 16'(blank), 16'h3);
        sel = 0; cyc();
        chk("blink_min", 16'(blank), 16'hc);
        clk_blink = 0; cyc();
        pulse2(12);
        sel = 1; pulse2(33);
        pause();
        exp_time("adj_hold_1234", 12, 34);
        chk("adj_hold_paused", 16'(paused), 16'h1);
        rst = 1; adj = 0; clk_1hz = 1; cyc(); rst = 0;
        exp_time("rst_digits", 0, 0);
        chk("rst_paused", 16'(paused), 16'h0);
        chk("rst_blank", 16'(blank), 16'h0);
        cyc();
        exp_time("post_rst_tick", 0, 1);
        clk_1hz = 0; cyc();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            pause_pulse = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0) sel = ~sel;
            if ($urandom_range(0, 2) == 0) clk_1hz = ~clk_1hz;
            if ($urandom_range(0, 1) == 0) clk_2hz = ~clk_2hz;
            if ($urandom_range(0, 3) == 0) clk_blink = ~clk_blink;
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
